mem_access_ctrl: RTL

Memory-stage sequencer that sits directly upstream of the LDR writeback mux. It accepts one instruction at a time from the execute stage, runs a req/ack transaction against data RAM for LDR/STR, and latches the RAM word into `ram_result`. It then drives `sel_ldr_mux`, `reg_we` and `reg_waddr` for exactly one writeback cycle, so the mux feeds the register bank the correct source. ALU-only instructions pass through the same writeback cycle with `sel_ldr_mux`=0.

---
 rtl/mem_access_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory-stage sequencer in front of the LDR writeback mux. It takes one
// instruction from execute, runs a req/ack transaction on data RAM for
// LDR/STR, and then gives the register bank a single writeback cycle.
//
// Handshakes:
//   start/busy : start is accepted only in a cycle where busy=0. While busy=1,
//                start and all instruction fields are ignored.
//   ram_req/ram_ack : ram_req is held with ram_we/ram_addr/ram_wdata stable
//                until the cycle in which ram_ack=1, or until the timeout.
//                ram_rdata is sampled in that ack cycle. ram_ack outside a
//                request is ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op_ldr, op_str, addr, store_data, rd_addr   instruction from execute
//   busy                stall to upstream (state != IDLE)
//   ram_req, ram_we, ram_addr, ram_wdata, ram_rdata, ram_ack   data RAM port
//   ram_result          latched LDR data for the writeback mux
//   sel_ldr_mux, reg_we, reg_waddr   writeback controls (valid in WB only)
//   done, err           one-cycle completion / failure pulses
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op_ldr,
  input  logic               op_str,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               busy,
  output logic               ram_req,
  output logic               ram_we,
  output logic [29:0]        ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata,
  input  logic               ram_ack,
  output logic [31:0]        ram_result,
  output logic               sel_ldr_mux,
  output logic               reg_we,
  output logic [RADDR_W-1:0] reg_waddr,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          cap_ldr;
  logic          cap_str;
  logic [CW-1:0] cnt;
  logic          last_req_cycle;

  // cnt holds the number of ack-less REQ cycles already completed, so the
  // TIMEOUT-th REQ cycle is the one where cnt == TIMEOUT-1.
  assign last_req_cycle = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (op_ldr && op_str)
            state_nxt = ERR;
          else if (op_ldr || op_str)
            state_nxt = (addr[1:0] != 2'b00) ? ERR : REQ;
          else
            state_nxt = WB;
        end
      end
      REQ: begin
        if (ram_ack)
          state_nxt = WB;
        else if (last_req_cycle)
          state_nxt = ERR;
      end
      WB:      state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_ldr    <= 1'b0;
      cap_str    <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      reg_waddr  <= '0;
      ram_result <= '0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        // Clearing in IDLE guarantees cnt is zero on every REQ entry.
        cnt <= '0;
        if (start) begin
          cap_ldr   <= op_ldr;
          cap_str   <= op_str;
          ram_addr  <= addr[31:2];
          ram_wdata <= store_data;
          reg_waddr <= rd_addr;
        end
      end
      if (state == REQ) begin
        if (ram_ack) begin
          if (cap_ldr)
            ram_result <= ram_rdata;
        end else if (!last_req_cycle) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Everything below decodes only from registered state.
  assign busy        = (state != IDLE);
  assign ram_req     = (state == REQ);
  assign ram_we      = (state == REQ) && cap_str;
  assign done        = (state == WB);
  assign err         = (state == ERR);
  // A WB state is reached only by LDR, STR or ALU (illegal goes to ERR),
  // so "not STR" means LDR or ALU, both of which write the register bank.
  assign reg_we      = (state == WB) && !cap_str;
  assign sel_ldr_mux = (state == WB) && cap_ldr;

endmodule
